alu_arbiter: RTL and testbench

Sequencer that shares the single 16-bit ALU among `NUM_REQ` requesters using round-robin arbitration. It accepts one operation at a time over a valid/ready handshake and drives opcode and operands to the ALU, holding them stable. It captures the ALU's combinational overflow flag and its one-cycle-registered result, then returns both to the granted requester on a tagged response channel. It sits between the requesting engines and the ALU instance, and is the only driver of the ALU inputs.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM states and opcode constants shared by alu_arbiter and its bench
package alu_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd7;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first valid at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j[IW-1:0]]) begin
        grant = '0;
        grant[j[IW-1:0]] = 1'b1;
        idx = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one ALU; ALU_ARB_ILLEGAL_OP_EN rejects opcodes above OP_LAST_LEGAL
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 16,
  parameter int OP_W = 4,
  parameter int ID_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_illegal,
  output logic [OP_W-1:0]         alu_opcode,
  output logic [DATA_W-1:0]       alu_operand_a,
  output logic [DATA_W-1:0]       alu_operand_b,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_overflow
);
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, id_q, win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic [OP_W-1:0] op_q, sel_op;
  logic [DATA_W-1:0] a_q, b_q, res_q, sel_a, sel_b;
  logic ovf_q, ill_q, take, illegal_op;
  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(win_grant),
    .idx(win_idx)
  );
  assign take = state == S_IDLE && |req_valid;
  assign req_ready = state == S_IDLE ? win_grant : '0;
  always_comb begin
    sel_op = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_grant[i]) begin
        sel_op = req_opcode[i*OP_W +: OP_W];
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
  end
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign illegal_op = sel_op > OP_W'(OP_LAST_LEGAL);
`else
  assign illegal_op = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (take ? (illegal_op ? S_RESP : S_ISSUE) : S_IDLE) :
               state == S_ISSUE ? S_CAPTURE :
               state == S_CAPTURE ? S_RESP :
               (rsp_ready ? S_IDLE : S_RESP);
  end
  // res_q/ovf_q clear at grant so a rejected opcode answers with zeros
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        rr_ptr <= win_idx == ID_W'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        id_q <= win_idx;
        ill_q <= illegal_op;
        res_q <= '0;
        ovf_q <= 1'b0;
        if (!illegal_op) begin
          op_q <= sel_op;
          a_q <= sel_a;
          b_q <= sel_b;
        end
      end
      if (state == S_ISSUE) ovf_q <= alu_overflow;
      if (state == S_CAPTURE) res_q <= alu_result;
    end
  assign rsp_valid = state == S_RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_illegal = ill_q;
  assign alu_opcode = op_q;
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  localparam int N = 4, DW = 16, OW = 4, IW = 2;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready;
  logic [N*OW-1:0] req_opcode;
  logic [N*DW-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_overflow, rsp_illegal;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_result, alu_operand_a, alu_operand_b, alu_result;
  logic [OW-1:0] alu_opcode;
  logic alu_overflow;
  logic [16:0] alu_now;
  int total = 0, bad = 0, model_ptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  // {overflow, result}; unknown opcodes give zero
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    logic o;
    r = '0;
    o = 1'b0;
    p = 32'(a) * 32'(b);
    case (op)
      OP_ADD: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_MUL: begin r = p[15:0]; o = |p[31:16]; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[3:0];
      OP_SHR: r = a >> b[3:0];
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  assign alu_now = alu_f(alu_opcode, alu_operand_a, alu_operand_b);
  assign alu_overflow = alu_now[16];
  always_ff @(posedge clk) alu_result <= alu_now[15:0];

  function automatic int pick(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[IW-1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_opcode[i*OW +: OW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // cycles from grant until rsp_valid, or -1 if it never comes; drops req_valid after the grant edge
  task automatic wait_rsp(output int n);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = '0;
      #1;
      if (rsp_valid) begin
        n = c;
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_illegal, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_rsp: got v=%b id=%0d res=%h ovf=%b ill=%b rdy=%b, want all 0", rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_illegal, req_ready);
    end
    total++;
    if ({alu_opcode, alu_operand_a, alu_operand_b} !== '0) begin
      bad++;
      $display("FAIL reset_alu: got op=%h a=%h b=%h, want 0", alu_opcode, alu_operand_a, alu_operand_b);
    end
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    int cyc, last, g, exp, n;
    cyc = 0;
    last = -1;
    g = 0;
    for (int i = 0; i < N; i++) set_req(i, OP_SUB, 16'($urandom), 16'($urandom));
    req_valid = '1;
    while (g < 5 && cyc < 40) begin
      #1;
      if (req_ready !== '0) begin
        exp = pick('1, model_ptr);
        total++;
        if (req_ready !== N'(1) << exp) begin
          bad++;
          $display("FAIL rr_order: grant %0d got ready=%b, want requester %0d", g, req_ready, exp);
        end
        if (g > 0) begin
          total++;
          if (cyc - last != 4) begin
            bad++;
            $display("FAIL rr_gap: grant %0d came %0d cycles after previous, want 4", g, cyc - last);
          end
        end
        last = cyc;
        g++;
        model_ptr = (exp + 1) % N;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    total++;
    if (g != 5) begin
      bad++;
      $display("FAIL rr_count: saw %0d grants, want 5", g);
    end
    wait_rsp(n);
    total++;
    if (n < 0) begin
      bad++;
      $display("FAIL rr_drain: no response within bound, want one");
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    set_req(0, OP_ADD, 16'h7FFF, 16'h0001);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b, want 0001", req_ready);
    end
    wait_rsp(n);
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL single_latency: got %0d, want 3", n);
    end
    total++;
    if (rsp_result !== 16'h8000 || rsp_overflow !== 1'b1 || rsp_id !== 2'd0 || rsp_illegal !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: got res=%h ovf=%b id=%0d ill=%b, want 8000 1 0 0", rsp_result, rsp_overflow, rsp_id, rsp_illegal);
    end
    model_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    set_req(3, OP_MUL, 16'h0003, 16'h0005);
    set_req(0, OP_AND, 16'hF0F0, 16'hFF00);
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL bp_grant: got %b, want 1000", req_ready);
    end
    model_ptr = 0;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h000F || rsp_id !== 2'd3 || req_ready !== '0) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d got v=%b res=%h id=%0d rdy=%b, want 1 000f 3 0000", c, rsp_valid, rsp_result, rsp_id, req_ready);
      end
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_next_grant: got %b, want 0001", req_ready);
    end
    wait_rsp(n);
    total++;
    if (n !== 3 || rsp_result !== 16'hF000 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL bp_second: got lat=%0d res=%h id=%0d, want 3 f000 0", n, rsp_result, rsp_id);
    end
    model_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_capture();
    int n;
    set_req(2, OP_XOR, 16'hAAAA, 16'h0FF0);
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rc_grant: got %b, want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_illegal, alu_opcode, alu_operand_a, alu_operand_b, req_ready} !== '0) begin
      bad++;
      $display("FAIL rc_outputs: got v=%b id=%0d res=%h op=%h a=%h b=%h, want all 0", rsp_valid, rsp_id, rsp_result, alu_opcode, alu_operand_a, alu_operand_b);
    end
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rc_no_rsp: cycle %0d got rsp_valid=%b, want 0", c, rsp_valid);
      end
      @(negedge clk);
    end
    set_req(3, OP_OR, 16'h1234, 16'h0001);
    req_valid = 4'b1100;
    #1;
    total++;
    if (req_ready !== N'(1) << pick(4'b1100, model_ptr)) begin
      bad++;
      $display("FAIL rc_ptr_restart: got %b, want 0100", req_ready);
    end
    wait_rsp(n);
    total++;
    if (n !== 3 || rsp_id !== 2'd2 || rsp_result !== 16'hA55A) begin
      bad++;
      $display("FAIL rc_rsp: got lat=%0d id=%0d res=%h, want 3 2 a55a", n, rsp_id, rsp_result);
    end
    model_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int n;
    logic [OW+2*DW-1:0] prev;
    prev = {alu_opcode, alu_operand_a, alu_operand_b};
    set_req(1, 4'b1010, 16'h1234, 16'h5678);
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL ill_grant: got %b, want 0010", req_ready);
    end
    wait_rsp(n);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    total++;
    if (n !== 1 || rsp_illegal !== 1'b1 || rsp_result !== '0 || rsp_overflow !== 1'b0 || rsp_id !== 2'd1) begin
      bad++;
      $display("FAIL ill_rsp: got lat=%0d ill=%b res=%h ovf=%b id=%0d, want 1 1 0 0 1", n, rsp_illegal, rsp_result, rsp_overflow, rsp_id);
    end
    total++;
    if ({alu_opcode, alu_operand_a, alu_operand_b} !== prev) begin
      bad++;
      $display("FAIL ill_alu_hold: got %h, want %h", {alu_opcode, alu_operand_a, alu_operand_b}, prev);
    end
`else
    total++;
    if (n !== 3 || rsp_illegal !== 1'b0 || rsp_result !== '0 || rsp_id !== 2'd1) begin
      bad++;
      $display("FAIL ill_rsp: got lat=%0d ill=%b res=%h id=%0d, want 3 0 0 1", n, rsp_illegal, rsp_result, rsp_id);
    end
    total++;
    if (alu_opcode !== 4'b1010 || {alu_opcode, alu_operand_a, alu_operand_b} === prev) begin
      bad++;
      $display("FAIL ill_alu_issue: got op=%h, want a", alu_opcode);
    end
`endif
    model_ptr = 2;
    @(negedge clk);
  endtask

  task automatic test_shift();
    int n;
    set_req(0, OP_SHL, 16'h0001, 16'h000F);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL shl_grant: got %b, want 0001", req_ready);
    end
    wait_rsp(n);
    total++;
    if (n !== 3 || rsp_result !== 16'h8000 || rsp_overflow !== 1'b0) begin
      bad++;
      $display("FAIL shl_rsp: got lat=%0d res=%h ovf=%b, want 3 8000 0", n, rsp_result, rsp_overflow);
    end
    model_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, exp, hold;
    logic [16:0] e;
    logic [N-1:0] mask;
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      exp = pick(mask, model_ptr);
      e = alu_f(req_opcode[exp*OW +: OW], req_a[exp*DW +: DW], req_b[exp*DW +: DW]);
      hold = $urandom_range(0, 3);
      rsp_ready = hold == 0;
      req_valid = mask;
      #1;
      total++;
      if (req_ready !== N'(1) << exp) begin
        bad++;
        $display("FAIL rnd_grant: iter %0d mask=%b got %b, want requester %0d", it, mask, req_ready, exp);
      end
      wait_rsp(n);
      total++;
      if (n !== 3 || rsp_id !== IW'(exp) || rsp_result !== e[15:0] || rsp_overflow !== e[16]) begin
        bad++;
        $display("FAIL rnd_rsp: iter %0d got lat=%0d id=%0d res=%h ovf=%b, want 3 %0d %h %b", it, n, rsp_id, rsp_result, rsp_overflow, exp, e[15:0], e[16]);
      end
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== e[15:0]) begin
          bad++;
          $display("FAIL rnd_hold: iter %0d got v=%b res=%h, want 1 %h", it, rsp_valid, rsp_result, e[15:0]);
        end
      end
      rsp_ready = 1'b1;
      model_ptr = (exp + 1) % N;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_reset_capture();
    test_illegal();
    test_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
